// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC register, next-PC redirect mux and IF/ID pipeline register
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] BranchTarget,
    input  logic [25:0] JumpIndex,
    input  logic [31:0] IDPCPlus4,
    input  logic [31:0] JrTarget,
    output logic [31:0] Address,
    input  logic [31:0] Instruction,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic [15:0] RedirectCount
);

    logic [31:0] r_pc;
    logic [31:0] r_if_id_instr;
    logic [31:0] r_if_id_pc_plus4;
    logic        r_if_id_valid;
    logic [15:0] r_redirect_count;

    logic [31:0] w_pc_plus4;
    logic        w_redirect;
    logic [31:0] w_target_raw;
    logic [31:0] w_target;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_redirect = (PCSrc != 2'b00);

    always_comb begin
        w_target_raw = BranchTarget;
        case (PCSrc)
            2'b01:   w_target_raw = BranchTarget;
            2'b10:   w_target_raw = {IDPCPlus4[31:28], JumpIndex, 2'b00};
            2'b11:   w_target_raw = JrTarget;
            default: w_target_raw = BranchTarget;
        endcase
    end

    // Targets are always word-aligned, whatever the source register held.
    assign w_target = {w_target_raw[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc             <= RESET_PC;
            r_if_id_instr    <= NOP_WORD;
            r_if_id_pc_plus4 <= 32'd0;
            r_if_id_valid    <= 1'b0;
            r_redirect_count <= 16'd0;
        end else if (w_redirect) begin
            // Redirect wins over Stall: the slot being fetched is squashed.
            r_pc             <= w_target;
            r_if_id_instr    <= NOP_WORD;
            r_if_id_pc_plus4 <= w_pc_plus4;
            r_if_id_valid    <= 1'b0;
            if (r_redirect_count != 16'hFFFF) begin
                r_redirect_count <= r_redirect_count + 16'd1;
            end
        end else begin
            if (!Stall) begin
                r_pc <= w_pc_plus4;
            end
            if (Flush) begin
                r_if_id_instr    <= NOP_WORD;
                r_if_id_pc_plus4 <= w_pc_plus4;
                r_if_id_valid    <= 1'b0;
            end else if (!Stall) begin
                r_if_id_instr    <= Instruction;
                r_if_id_pc_plus4 <= w_pc_plus4;
                r_if_id_valid    <= 1'b1;
            end
        end
    end

    assign Address           = r_pc;
    assign IF_ID_Instruction = r_if_id_instr;
    assign IF_ID_PCPlus4     = r_if_id_pc_plus4;
    assign IF_ID_Valid       = r_if_id_valid;
    assign RedirectCount     = r_redirect_count;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage against a behavioural model
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h00000000;
    localparam logic [31:0] NOP_WORD = 32'h00000000;

    logic        clk;
    logic        reset;
    logic        Stall;
    logic        Flush;
    logic [1:0]  PCSrc;
    logic [31:0] BranchTarget;
    logic [25:0] JumpIndex;
    logic [31:0] IDPCPlus4;
    logic [31:0] JrTarget;
    logic [31:0] Address;
    logic [31:0] Instruction;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic [15:0] RedirectCount;

    logic [31:0] mem [256];

    logic [31:0] m_pc;
    logic [31:0] m_ins;
    logic [31:0] m_p4;
    logic        m_v;
    int unsigned m_cnt;

    int n_checks;
    int n_pass;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
        .clk               (clk),
        .reset             (reset),
        .Stall             (Stall),
        .Flush             (Flush),
        .PCSrc             (PCSrc),
        .BranchTarget      (BranchTarget),
        .JumpIndex         (JumpIndex),
        .IDPCPlus4         (IDPCPlus4),
        .JrTarget          (JrTarget),
        .Address           (Address),
        .Instruction       (Instruction),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_PCPlus4     (IF_ID_PCPlus4),
        .IF_ID_Valid       (IF_ID_Valid),
        .RedirectCount     (RedirectCount)
    );

    assign Instruction = mem[Address[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Next state from the architectural rules, using current inputs and model state.
    task automatic model_update();
        logic [31:0] seq;
        logic [31:0] tgt;
        seq = m_pc + 32'd4;
        if (reset) begin
            m_pc = RESET_PC; m_ins = NOP_WORD; m_p4 = 0; m_v = 0; m_cnt = 0;
        end else if (PCSrc != 2'b00) begin
            if (PCSrc == 2'b01)      tgt = BranchTarget;
            else if (PCSrc == 2'b10) tgt = {IDPCPlus4[31:28], 28'h0} + {4'h0, JumpIndex, 2'b00};
            else                     tgt = JrTarget;
            m_pc  = tgt - (tgt % 4);
            m_ins = NOP_WORD; m_p4 = seq; m_v = 0;
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        end else if (Flush) begin
            m_ins = NOP_WORD; m_p4 = seq; m_v = 0;
            if (!Stall) m_pc = seq;
        end else if (!Stall) begin
            m_ins = mem[(m_pc / 4) % 256]; m_p4 = seq; m_v = 1;
            m_pc  = seq;
        end
    endtask

    task automatic compare_all();
        check("address", Address, m_pc);
        check("if_id_instr", IF_ID_Instruction, m_ins);
        check("if_id_pcplus4", IF_ID_PCPlus4, m_p4);
        check("if_id_valid", {31'd0, IF_ID_Valid}, {31'd0, m_v});
        check("redirect_count", {16'd0, RedirectCount}, m_cnt);
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        reset = 0; Stall = 0; Flush = 0; PCSrc = 2'b00;
        BranchTarget = 0; JumpIndex = 0; IDPCPlus4 = 0; JrTarget = 0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h20040000;
        mem[1] = 32'h20040000;
        mem[2] = 32'h20050003;
        mem[3] = 32'hac850000;
        m_pc = 0; m_ins = 0; m_p4 = 0; m_v = 0; m_cnt = 0;

        idle_inputs();
        reset = 1;
        step();
        step();
        check("reset_address", Address, RESET_PC);
        check("reset_valid", {31'd0, IF_ID_Valid}, 32'd0);
        reset = 0;

        // Sequential fetch of the program
        step();
        check("seq_addr4", Address, 32'd4);
        check("seq_ins0", IF_ID_Instruction, 32'h20040000);
        step();
        check("seq_addr8", Address, 32'd8);

        // Stall for three cycles at PC 8
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr", Address, 32'd8);
            check("stall_ins", IF_ID_Instruction, 32'h20040000);
            check("stall_p4", IF_ID_PCPlus4, 32'd8);
            check("stall_valid", {31'd0, IF_ID_Valid}, 32'd1);
        end
        Stall = 0;
        step();
        check("release_addr", Address, 32'd12);
        check("release_ins", IF_ID_Instruction, 32'h20050003);

        // Jump
        PCSrc = 2'b10; JumpIndex = 26'h000000C; IDPCPlus4 = 32'h30;
        step();
        check("jump_addr", Address, 32'h30);
        check("jump_bubble", {31'd0, IF_ID_Valid}, 32'd0);
        check("jump_count", {16'd0, RedirectCount}, 32'd1);
        PCSrc = 2'b00;
        step();
        check("after_jump_valid", {31'd0, IF_ID_Valid}, 32'd1);

        // Jump-register together with a stall
        PCSrc = 2'b11; JrTarget = 32'h4E; Stall = 1;
        step();
        check("jr_addr", Address, 32'h4C);
        check("jr_bubble", {31'd0, IF_ID_Valid}, 32'd0);
        check("jr_ins", IF_ID_Instruction, NOP_WORD);
        PCSrc = 2'b00; Stall = 0;

        // Branch to 0x10, then flush
        PCSrc = 2'b01; BranchTarget = 32'h10;
        step();
        PCSrc = 2'b00; Flush = 1;
        step();
        check("flush_addr", Address, 32'h14);
        check("flush_ins", IF_ID_Instruction, 32'd0);
        check("flush_valid", {31'd0, IF_ID_Valid}, 32'd0);
        check("flush_p4", IF_ID_PCPlus4, 32'h14);
        Flush = 0;

        // Stall with flush: PC holds, IF/ID bubbles
        Stall = 1; Flush = 1;
        step();
        check("stallflush_addr", Address, 32'h14);
        check("stallflush_valid", {31'd0, IF_ID_Valid}, 32'd0);
        Stall = 0; Flush = 0;

        // PC wrap at the top of the address space
        PCSrc = 2'b11; JrTarget = 32'hFFFFFFFF;
        step();
        check("near_top", Address, 32'hFFFFFFFC);
        PCSrc = 2'b00;
        step();
        check("wrap_addr", Address, 32'd0);
        check("wrap_p4", IF_ID_PCPlus4, 32'd0);

        // Reset beats redirect
        reset = 1; PCSrc = 2'b01; BranchTarget = 32'h100;
        step();
        check("rst_redirect_addr", Address, RESET_PC);
        check("rst_redirect_count", {16'd0, RedirectCount}, 32'd0);
        idle_inputs();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            reset        = ($urandom_range(0, 99) == 0);
            Stall        = ($urandom_range(0, 3) == 0);
            Flush        = ($urandom_range(0, 5) == 0);
            PCSrc        = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            BranchTarget = $urandom;
            JumpIndex    = 26'($urandom);
            IDPCPlus4    = $urandom;
            JrTarget     = $urandom;
            step();
        end
        idle_inputs();

        // Saturation of the redirect counter
        reset = 1;
        step();
        reset = 0;
        PCSrc = 2'b01;
        for (int i = 0; i < 65540; i++) begin
            BranchTarget = $urandom;
            step();
        end
        check("count_saturated", {16'd0, RedirectCount}, 32'h0000FFFF);
        idle_inputs();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
